fragment_writer: RTL

//  Consumes fragments from the fragment generator's output FIFO. Each fragment is tested for

---
 rtl/fragment_writer_if.sv | 10 +
 rtl/fragment_writer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fragment_writer_if.sv
// Framebuffer write-request bus between fragment_writer (master) and memory (slave).
interface fragment_writer_if;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;

  modport master (output mem_req_val, mem_req_addr, mem_req_data, input mem_req_ready);
  modport slave  (input mem_req_val, mem_req_addr, mem_req_data, output mem_req_ready);
endinterface

// File: rtl/fragment_writer.sv
// Last rasterizer stage: culls fragments by coverage and bounds, turns survivors into
// framebuffer colour writes through a small output queue, and signals done after draining.
module fragment_writer #(
  parameter int LG_OUT_Q = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fb_base,
  input  logic [15:0] fb_stride,
  input  logic [15:0] fb_width,
  input  logic [15:0] fb_height,
  input  logic [31:0] color,
  input  logic        frag_val,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] w0_in,
  input  logic [31:0] w1_in,
  input  logic [31:0] w2_in,
  output logic        pop_frag,
  input  logic        gen_done,
  fragment_writer_if.master mem,
  output logic        busy,
  output logic        done,
  output logic [31:0] frag_cnt,
  output logic [31:0] write_cnt
);

  localparam int DEPTH = 1 << LG_OUT_Q;
  localparam int CW    = LG_OUT_Q + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [31:0] base_r;
  logic [31:0] color_r;
  logic [15:0] stride_r;
  logic [15:0] width_r;
  logic [15:0] height_r;

  logic        s1_val;
  logic        s1_cover;
  logic        s1_inb;
  logic [15:0] s1_x;
  logic [15:0] s1_y;

  logic        s2_val;
  logic        s2_keep;
  logic [31:0] s2_addr;

  logic [LG_OUT_Q:0] wr_ptr;
  logic [LG_OUT_Q:0] rd_ptr;
  logic [LG_OUT_Q:0] q_count;
  logic [31:0]       q_addr [DEPTH];
  logic [31:0]       q_data [DEPTH];

  logic          q_empty;
  logic          enq;
  logic          deq;
  logic          credit_ok;
  logic          accept_start;
  logic          drain_empty;
  logic [CW-1:0] in_flight;
  logic [31:0]   pix_index;

  // Sign bit clear, or a zero magnitude so that -0.0 still counts as covered.
  function automatic logic not_negative(input logic [31:0] w);
    return !w[31] || (w[30:0] == 31'd0);
  endfunction

  assign accept_start = start && (state == IDLE);
  assign q_count      = wr_ptr - rd_ptr;
  assign q_empty      = (wr_ptr == rd_ptr);
  // Reserve a queue slot for every fragment already in S1/S2 so S2 never meets a full queue.
  assign in_flight    = CW'(q_count) + CW'(s1_val) + CW'(s2_val);
  assign credit_ok    = in_flight < CW'(DEPTH);
  assign pop_frag     = frag_val && (state == RUN || state == DRAIN) && credit_ok;
  assign enq          = s2_val && s2_keep;
  assign deq          = !q_empty && mem.mem_req_ready;
  assign drain_empty  = !frag_val && !s1_val && !s2_val && q_empty;
  assign pix_index    = ({16'd0, s1_y} * {16'd0, stride_r}) + {16'd0, s1_x};

  assign mem.mem_req_val  = !q_empty;
  assign mem.mem_req_addr = q_empty ? 32'd0 : q_addr[rd_ptr[LG_OUT_Q-1:0]];
  assign mem.mem_req_data = q_empty ? 32'd0 : q_data[rd_ptr[LG_OUT_Q-1:0]];
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (gen_done) state_next = DRAIN;
      DRAIN: begin
        if (drain_empty) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      color_r  <= '0;
      stride_r <= '0;
      width_r  <= '0;
      height_r <= '0;
    end else if (accept_start) begin
      base_r   <= fb_base;
      color_r  <= color;
      stride_r <= fb_stride;
      width_r  <= fb_width;
      height_r <= fb_height;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val   <= 1'b0;
      s1_cover <= 1'b0;
      s1_inb   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s2_val   <= 1'b0;
      s2_keep  <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s1_val <= pop_frag;
      if (pop_frag) begin
        s1_x     <= x_in[15:0];
        s1_y     <= y_in[15:0];
        s1_cover <= not_negative(w0_in) && not_negative(w1_in) && not_negative(w2_in);
        s1_inb   <= (x_in < {16'd0, width_r}) && (y_in < {16'd0, height_r});
      end
      s2_val <= s1_val;
      if (s1_val) begin
        s2_keep <= s1_cover && s1_inb;
        s2_addr <= base_r + (pix_index << 2);
      end
    end
  end

  // Queue storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr[LG_OUT_Q-1:0]] <= s2_addr;
      q_data[wr_ptr[LG_OUT_Q-1:0]] <= color_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      frag_cnt  <= '0;
      write_cnt <= '0;
    end else begin
      if (pop_frag) frag_cnt  <= frag_cnt + 32'd1;
      if (deq)      write_cnt <= write_cnt + 32'd1;
    end
  end

endmodule
